// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Owns the architectural fetch PC and picks the next fetch
//               address for the IF stage: sequential, branch, jump,
//               jump-register, ERET or interrupt entry. Holds the PC on
//               hazard stalls and marks the wrong-path fetch after an
//               ERET / exception redirect as a bubble (FLUSH cycle).
// Optional    : PC_ALIGN_CHECK_EN - misaligned redirect targets raise an
//               address-error exception and add the oAdEL output.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               iStall            - hold PC and state
//               iNPC_sel          - 0 SEQ,1 BRANCH,2 JUMP,3 JUMPREG,4 ERET
//               iBranchTarget/iJumpTarget/iJrTarget/iEPC - redirect targets
//               iIntReq           - interrupt request (level or pulse)
//               iInDelaySlot      - D-stage instruction is a delay slot
//               oPC               - fetch address to IM
//               oValid / oFlush   - fetch valid / kill IF/ID this cycle
//               oExcTake,oEPC,oBD - exception accept pulse and CP0 data
//               oSelErr           - illegal iNPC_sel pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iStall,
  input  logic [2:0]  iNPC_sel,
  input  logic [31:0] iBranchTarget,
  input  logic [31:0] iJumpTarget,
  input  logic [31:0] iJrTarget,
  input  logic [31:0] iEPC,
  input  logic        iIntReq,
  input  logic        iInDelaySlot,
  output logic [31:0] oPC,
  output logic        oValid,
  output logic        oFlush,
  output logic        oExcTake,
  output logic [31:0] oEPC,
  output logic        oBD,
  output logic        oSelErr
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        oAdEL
`endif
);

  localparam logic [2:0] SEL_SEQ     = 3'd0;
  localparam logic [2:0] SEL_BRANCH  = 3'd1;
  localparam logic [2:0] SEL_JUMP    = 3'd2;
  localparam logic [2:0] SEL_JUMPREG = 3'd3;
  localparam logic [2:0] SEL_ERET    = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic        exc_take_q, exc_take_d;
  logic        sel_err_q, sel_err_d;
  logic        int_pend_q, int_pend_d;
`ifdef PC_ALIGN_CHECK_EN
  logic        adel_q, adel_d;
`endif

  logic        int_accept;
  logic        redirect;
  logic        is_eret;
  logic [31:0] target;
  logic [31:0] seq_pc;

  // A pending interrupt is never taken in the FLUSH cycle so that the
  // victim PC reported to CP0 always belongs to a real instruction.
  assign int_accept = (iIntReq | int_pend_q) & ~iStall & (state_q != ST_FLUSH);
  assign seq_pc     = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    exc_take_d = 1'b0;
    sel_err_d  = 1'b0;
    int_pend_d = int_pend_q | iIntReq;
    redirect   = 1'b0;
    is_eret    = 1'b0;
    target     = 32'd0;
`ifdef PC_ALIGN_CHECK_EN
    adel_d     = 1'b0;
`endif

    if (int_accept) begin
      pc_d       = EXC_VECTOR;
      // D-stage PC is oPC-4; a delay-slot victim restarts at its branch.
      epc_d      = iInDelaySlot ? (pc_q - 32'd8) : (pc_q - 32'd4);
      bd_d       = iInDelaySlot;
      exc_take_d = 1'b1;
      int_pend_d = 1'b0;
      state_d    = ST_FLUSH;
    end else if (state_q == ST_FLUSH) begin
      // The D stage holds the killed instruction, so its select is
      // meaningless; fetch simply continues and stalls are ignored.
      pc_d    = seq_pc;
      state_d = ST_RUN;
    end else if (iStall) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
      case (iNPC_sel)
        SEL_SEQ:     pc_d = seq_pc;
        SEL_BRANCH:  begin redirect = 1'b1; target = iBranchTarget; end
        SEL_JUMP:    begin redirect = 1'b1; target = iJumpTarget;   end
        SEL_JUMPREG: begin redirect = 1'b1; target = iJrTarget;     end
        SEL_ERET:    begin redirect = 1'b1; target = iEPC; is_eret = 1'b1; end
        default: begin
          pc_d      = seq_pc;
          sel_err_d = 1'b1;
        end
      endcase

      if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
        if (target[1:0] != 2'b00) begin
          pc_d       = EXC_VECTOR;
          epc_d      = target;
          bd_d       = 1'b0;
          exc_take_d = 1'b1;
          adel_d     = 1'b1;
          state_d    = ST_FLUSH;
        end else begin
          pc_d = target;
          if (is_eret) state_d = ST_FLUSH;
        end
`else
        pc_d = target;
        // Branch/jump delay slots stay valid; only ERET discards its
        // already-fetched successor.
        if (is_eret) state_d = ST_FLUSH;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      epc_q      <= 32'd0;
      bd_q       <= 1'b0;
      exc_take_q <= 1'b0;
      sel_err_q  <= 1'b0;
      int_pend_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      adel_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      exc_take_q <= exc_take_d;
      sel_err_q  <= sel_err_d;
      int_pend_q <= int_pend_d;
`ifdef PC_ALIGN_CHECK_EN
      adel_q     <= adel_d;
`endif
    end
  end

  assign oPC      = pc_q;
  assign oValid   = (state_q != ST_FLUSH);
  assign oFlush   = (state_q == ST_FLUSH);
  assign oExcTake = exc_take_q;
  assign oEPC     = epc_q;
  assign oBD      = bd_q;
  assign oSelErr  = sel_err_q;
`ifdef PC_ALIGN_CHECK_EN
  assign oAdEL    = adel_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A behavioural model
//               tracks the fetch PC, the pending interrupt and whether the
//               next cycle is a bubble, and is compared every cycle against
//               the DUT outputs under directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iStall = 1'b0;
  logic [2:0]  iNPC_sel = 3'd0;
  logic [31:0] iBranchTarget = 32'd0;
  logic [31:0] iJumpTarget = 32'd0;
  logic [31:0] iJrTarget = 32'd0;
  logic [31:0] iEPC = 32'd0;
  logic        iIntReq = 1'b0;
  logic        iInDelaySlot = 1'b0;
  logic [31:0] oPC;
  logic        oValid, oFlush, oExcTake, oBD, oSelErr;
  logic [31:0] oEPC;
`ifdef PC_ALIGN_CHECK_EN
  logic        oAdEL;
`endif

  pc_sequencer #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk(clk), .reset(reset), .iStall(iStall), .iNPC_sel(iNPC_sel),
    .iBranchTarget(iBranchTarget), .iJumpTarget(iJumpTarget),
    .iJrTarget(iJrTarget), .iEPC(iEPC), .iIntReq(iIntReq),
    .iInDelaySlot(iInDelaySlot), .oPC(oPC), .oValid(oValid),
    .oFlush(oFlush), .oExcTake(oExcTake), .oEPC(oEPC), .oBD(oBD),
    .oSelErr(oSelErr)
`ifdef PC_ALIGN_CHECK_EN
    , .oAdEL(oAdEL)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the outputs must show after the next edge.
  bit [31:0] m_pc = RESET_PC;
  bit        m_pend = 0;
  bit        m_flush = 0;
  bit        m_exc = 0;
  bit [31:0] m_epc = 0;
  bit        m_bd = 0;
  bit        m_selerr = 0;
  bit        m_adel = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the sequencing rules for one rising edge to the model.
  task automatic model_edge();
    bit        was_flush;
    bit        redir;
    bit [31:0] tgt;
    m_exc = 0; m_selerr = 0; m_adel = 0;
    if (reset) begin
      m_pc = RESET_PC; m_pend = 0; m_flush = 0; m_epc = 0; m_bd = 0;
      return;
    end
    was_flush = m_flush;
    m_flush   = 0;
    if ((iIntReq || m_pend) && !iStall && !was_flush) begin
      m_epc   = m_pc - (iInDelaySlot ? 32'd8 : 32'd4);
      m_bd    = iInDelaySlot;
      m_exc   = 1;
      m_pend  = 0;
      m_pc    = EXC_VECTOR;
      m_flush = 1;
      return;
    end
    if (iIntReq) m_pend = 1;
    if (was_flush) begin m_pc = m_pc + 4; return; end
    if (iStall) return;
    redir = 1;
    tgt   = 0;
    case (iNPC_sel)
      3'd1: tgt = iBranchTarget;
      3'd2: tgt = iJumpTarget;
      3'd3: tgt = iJrTarget;
      3'd4: tgt = iEPC;
      default: redir = 0;
    endcase
    if (!redir) begin
      m_pc = m_pc + 4;
      if (iNPC_sel > 3'd4) m_selerr = 1;
      return;
    end
`ifdef PC_ALIGN_CHECK_EN
    if (tgt[1:0] != 2'b00) begin
      m_pc = EXC_VECTOR; m_epc = tgt; m_bd = 0; m_exc = 1; m_adel = 1; m_flush = 1;
      return;
    end
`endif
    m_pc = tgt;
    if (iNPC_sel == 3'd4) m_flush = 1;
  endtask

  // Inputs are set on the falling edge; outputs are sampled 1ns after the rise.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_val("pc", oPC, m_pc);
    check_val("valid", {31'd0, oValid}, {31'd0, !m_flush});
    check_val("flush", {31'd0, oFlush}, {31'd0, m_flush});
    check_val("exc_take", {31'd0, oExcTake}, {31'd0, m_exc});
    check_val("sel_err", {31'd0, oSelErr}, {31'd0, m_selerr});
    if (m_exc) begin
      check_val("epc", oEPC, m_epc);
      check_val("bd", {31'd0, oBD}, {31'd0, m_bd});
    end
`ifdef PC_ALIGN_CHECK_EN
    check_val("adel", {31'd0, oAdEL}, {31'd0, m_adel});
`endif
    @(negedge clk);
  endtask

  task automatic drive_idle();
    reset = 0; iStall = 0; iNPC_sel = 3'd0; iIntReq = 0; iInDelaySlot = 0;
  endtask

  initial begin
    @(negedge clk);
    // Reset for two cycles.
    reset = 1;
    tick();
    tick();
    check_val("rst_pc", oPC, 32'h3000);
    check_val("rst_epc", oEPC, 32'd0);
    check_val("rst_bd", {31'd0, oBD}, 32'd0);
    check_val("rst_valid", {31'd0, oValid}, 32'd1);

    // Sequential fetch.
    drive_idle();
    tick(); check_val("seq1", oPC, 32'h3004);
    tick(); check_val("seq2", oPC, 32'h3008);
    tick(); check_val("seq3", oPC, 32'h300C);
    tick(); check_val("seq4", oPC, 32'h3010);

    // Branch: no flush, delay slot stays valid.
    iNPC_sel = 3'd1; iBranchTarget = 32'h3100;
    tick(); check_val("branch_pc", oPC, 32'h3100);
    check_val("branch_noflush", {31'd0, oFlush}, 32'd0);

    // Stall holds the PC for three cycles, then fetch resumes.
    iNPC_sel = 3'd2; iJumpTarget = 32'h3020;
    tick();
    iStall = 1; iNPC_sel = 3'd1; iBranchTarget = 32'h5555_0000;
    repeat (3) tick();
    check_val("stall_hold", oPC, 32'h3020);
    iStall = 0; iNPC_sel = 3'd0;
    tick(); check_val("stall_release", oPC, 32'h3024);

    // Interrupt pulse at 3040, not in a delay slot.
    iNPC_sel = 3'd2; iJumpTarget = 32'h3040;
    tick();
    iNPC_sel = 3'd0; iIntReq = 1;
    tick(); iIntReq = 0;
    check_val("irq_pc", oPC, EXC_VECTOR);
    check_val("irq_epc", oEPC, 32'h303C);
    check_val("irq_flush", {31'd0, oFlush}, 32'd1);
    tick();

    // Interrupt held off by a two-cycle stall, taken when it drops.
    iNPC_sel = 3'd2; iJumpTarget = 32'h3050;
    tick();
    iIntReq = 1; iStall = 1;
    repeat (2) tick();
    iIntReq = 0; iStall = 0;
    tick();
    check_val("irq_stall_epc", oEPC, 32'h304C);
    tick();

    // ERET redirects and flushes.
    iNPC_sel = 3'd4; iEPC = 32'h3078;
    tick(); check_val("eret_pc", oPC, 32'h3078);
    iNPC_sel = 3'd0;
    tick();

    // Interrupt with ERET: interrupt wins; delay-slot victim.
    iNPC_sel = 3'd4; iEPC = 32'h7000; iIntReq = 1; iInDelaySlot = 1;
    tick(); check_val("irq_eret_pc", oPC, EXC_VECTOR);
    drive_idle();
    tick();

    // Illegal select and 32-bit wrap.
    iNPC_sel = 3'd6;
    tick();
    iNPC_sel = 3'd3; iJrTarget = 32'hFFFF_FFFC;
    tick();
    iNPC_sel = 3'd0;
    tick(); check_val("wrap", oPC, 32'h0000_0000);

`ifdef PC_ALIGN_CHECK_EN
    iNPC_sel = 3'd3; iJrTarget = 32'h3002;
    tick(); check_val("adel_epc", oEPC, 32'h3002);
    iNPC_sel = 3'd0;
    tick();
`endif

    // Randomized traffic; reset occasionally fires mid-stall or mid-flush.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      iStall        = ($urandom_range(0, 4) == 0);
      iIntReq       = ($urandom_range(0, 19) == 0);
      iInDelaySlot  = $urandom_range(0, 1) == 1;
      iNPC_sel      = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      iBranchTarget = $urandom & 32'hFFFF_FFFE;
      iJumpTarget   = $urandom & 32'hFFFF_FFFC;
      iJrTarget     = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      iEPC          = $urandom & 32'hFFFF_FFFC;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
